instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Instruction supply side of the 16-bit RISC_Processor `instruction` interface: the producer that feeds the decoder.
- Holds a loadable instruction memory and a program counter.
- Fetches sequentially, consumes HALT and JMP internally, and issues all other instructions over a valid/ready handshake.
- Sits between program-load logic (or a testbench) and the processor core; replaces hand-driven instruction stimulus.

Parameters:
- ADDR_W, 8, instruction memory address and PC width.
- DEPTH, 256, memory words (2**ADDR_W); PC wraps modulo DEPTH.
- HALT_OP, 4'b1111, opcode consumed as HALT (not issued).
- JMP_OP, 4'b1110, opcode consumed as absolute jump; target = instr[ADDR_W-1:0].

Ports:
- clk, input, 1, system clock; all state on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, pulse; begins fetch from PC 0 when in IDLE or HALT.
- load_en, input, 1, memory write strobe; honoured only in IDLE or HALT.
- load_addr, input, ADDR_W, memory write address.
- load_data, input, 16, memory write data.
- instr_out, output, 16, instruction to processor: [15:12] op, [11:8] rd, [7:4] rs1, [3:0] rs2.
- instr_valid, output, 1, instr_out valid.
- instr_ready, input, 1, processor accepts instr_out this cycle.
- pc_out, output, ADDR_W, address of instruction currently in instr_out.
- redirect_en, input, 1, branch redirect from core.
- redirect_pc, input, ADDR_W, redirect target.
- busy, output, 1, high in FETCH or ISSUE.
- halted, output, 1, high in HALT.

Behaviour:
- Reset is asynchronous and active-low on rst_n, single clock clk.
- Reset values:
  - state = IDLE; PC = 0.
  - instr_out = 16'h0000; instr_valid = 0; pc_out = 0; busy = 0; halted = 0.
  - Memory contents are not reset.
- IDLE:
  - load_en writes mem[load_addr] <= load_data.
  - start -> FETCH with PC = 0.
- FETCH:
  - Synchronous read: instr_out <= mem[PC]; pc_out <= PC; PC <= PC+1 (wraps DEPTH-1 -> 0).
  - Next state depends on the fetched opcode:
    - HALT_OP -> HALT; instr_valid stays 0.
    - JMP_OP -> PC <= target; stay in FETCH; instr_valid stays 0.
    - Any other opcode -> ISSUE with instr_valid = 1.
- ISSUE:
  - instr_out and pc_out are held stable while instr_valid = 1 and instr_ready = 0.
  - instr_valid & instr_ready -> accepted; instr_valid drops next cycle; -> FETCH.
  - Issue latency: 2 cycles per instruction (one FETCH, at least one ISSUE); throughput 1 per 2 clocks at full ready.
- Redirect (honoured in FETCH and ISSUE; ignored in IDLE and HALT):
  - In ISSUE, redirect_en with no accept: current instruction is dropped; instr_valid = 0 next cycle; PC <= redirect_pc; -> FETCH.
  - In ISSUE, redirect_en with accept in the same cycle: instruction counts as issued; PC <= redirect_pc; -> FETCH.
  - In FETCH: redirect_en overrides the sequential PC and any JMP target; the fetched word is discarded; stay in FETCH.
- HALT:
  - halted = 1; load_en honoured.
  - start -> FETCH from PC 0.
- load_en in FETCH or ISSUE is ignored, with no memory change.
- start while busy is ignored.
- rst_n low mid-operation: immediate return to reset values; an in-flight instruction is lost.

Optional Feature:
- Macro: FETCH_ISSUE_COUNT_EN.
- With the macro defined:
  - Adds output issue_cnt[15:0], reset 0.
  - Increments on each instr_valid & instr_ready handshake; wraps 16'hFFFF -> 0.
  - Clears on start.
  - HALT, JMP and dropped instructions are not counted.
- Without the macro: port and counter are absent; behaviour otherwise identical.

Test Plan:
- Load mem[0]=16'h0123, mem[1]=16'h1123, mem[2]=16'hF000; start; ready=1 -> issues 0123 (pc 0), then 1123 (pc 1); halted=1 about 6 cycles after start; issue_cnt=2.
- Ready held low 5 cycles during ISSUE of 16'h0123 -> instr_out and pc_out stable, valid high throughout; accepted once when ready rises.
- mem[0]=16'hE005, mem[5]=16'h2456, mem[6]=16'hF000 -> only 2456 issued, with pc_out=5; JMP never valid.
- ISSUE of pc 1 with redirect_en=1, redirect_pc=8, ready=0 -> instruction dropped; next issued pc_out=8; issue_cnt unchanged.
- Program ending at mem[255]=16'h0111 with no HALT -> after pc 255 issue, PC wraps and next fetch is mem[0].
- rst_n asserted during ISSUE -> valid=0, busy=0, pc_out=0 immediately; load_en during busy leaves memory unchanged.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: loadable instruction memory plus program counter.
// Fetches sequentially, consumes HALT and JMP internally, and issues every
// other word to the core over a valid/ready handshake.
// Optional feature macro: FETCH_ISSUE_COUNT_EN adds the issue_cnt output.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | after reset; memory loadable; waiting for start
// S_FETCH | read mem[pc]; decode HALT / JMP / issuable word
// S_ISSUE | instr_valid high; holding instr_out until accept or redirect
// S_HALT  | HALT consumed; memory loadable; waiting for start
module instr_fetch_unit #(
  parameter int         ADDR_W  = 8,
  parameter int         DEPTH   = 256,
  parameter logic [3:0] HALT_OP = 4'b1111,
  parameter logic [3:0] JMP_OP  = 4'b1110
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [15:0]       load_data,
  output logic [15:0]       instr_out,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc_out,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              busy,
  output logic              halted
`ifdef FETCH_ISSUE_COUNT_EN
  ,
  output logic [15:0]       issue_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_HALT} state_t;

  state_t            state, state_nxt;
  logic [15:0]       mem [DEPTH];
  logic [ADDR_W-1:0] pc, pc_nxt, pc_inc;
  logic [15:0]       fetch_word;
  logic [3:0]        fetch_op;
  logic              idle_like;
  logic              fetch_take;

  assign fetch_word  = mem[pc];
  assign fetch_op    = fetch_word[15:12];
  assign pc_inc      = (pc == ADDR_W'(DEPTH - 1)) ? '0 : pc + ADDR_W'(1);
  assign idle_like   = (state == S_IDLE) || (state == S_HALT);
  // A redirect during FETCH discards the word just read.
  assign fetch_take  = (state == S_FETCH) && !redirect_en;

  assign instr_valid = (state == S_ISSUE);
  assign busy        = (state == S_FETCH) || (state == S_ISSUE);
  assign halted      = (state == S_HALT);

  // Next-state and next-PC selection.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_nxt = S_FETCH;
          pc_nxt    = '0;
        end
      end
      S_FETCH: begin
        if (redirect_en) begin
          pc_nxt = redirect_pc;
        end else if (fetch_op == HALT_OP) begin
          state_nxt = S_HALT;
          pc_nxt    = pc_inc;
        end else if (fetch_op == JMP_OP) begin
          pc_nxt = fetch_word[ADDR_W-1:0];
        end else begin
          state_nxt = S_ISSUE;
          pc_nxt    = pc_inc;
        end
      end
      S_ISSUE: begin
        // Redirect wins over plain accept for the PC; an accept in the same
        // cycle still counts as issued.
        if (redirect_en) begin
          state_nxt = S_FETCH;
          pc_nxt    = redirect_pc;
        end else if (instr_ready) begin
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and program counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pc    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // Output instruction register; held stable through ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_out <= 16'h0000;
      pc_out    <= '0;
    end else if (fetch_take) begin
      instr_out <= fetch_word;
      pc_out    <= pc;
    end
  end

  // Program load port; memory contents survive reset.
  always_ff @(posedge clk) begin
    if (load_en && idle_like) begin
      mem[load_addr] <= load_data;
    end
  end

`ifdef FETCH_ISSUE_COUNT_EN
  // Count accepted handshakes since the last start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt <= 16'h0000;
    end else if (idle_like && start) begin
      issue_cnt <= 16'h0000;
    end else if (instr_valid && instr_ready) begin
      issue_cnt <= issue_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: randomized ready/program stimulus checked
// against a program-walking reference model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        load_en = 1'b0;
  logic [7:0]  load_addr = '0;
  logic [15:0] load_data = '0;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [7:0]  pc_out;
  logic        redirect_en = 1'b0;
  logic [7:0]  redirect_pc = '0;
  logic        busy;
  logic        halted;
`ifdef FETCH_ISSUE_COUNT_EN
  logic [15:0] issue_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [15:0] ref_mem [256];
  int          exp_pc [$];
  logic [15:0] exp_in [$];
  bit          exp_halt;
  int          exp_cyc;
  int          cap_pc [$];
  logic [15:0] cap_in [$];
  int          stab_err;
  bit          halted_seen;
  int          halt_cyc;

  instr_fetch_unit dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .load_en(load_en),
    .load_addr(load_addr),
    .load_data(load_data),
    .instr_out(instr_out),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .pc_out(pc_out),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .busy(busy),
    .halted(halted)
`ifdef FETCH_ISSUE_COUNT_EN
    ,
    .issue_cnt(issue_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic load_word(input int a, input logic [15:0] d);
    @(negedge clk);
    load_en = 1'b1;
    load_addr = 8'(a);
    load_data = d;
    @(negedge clk);
    load_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Walk the program as the architecture defines it: HALT stops, JMP moves
  // the PC, everything else is issued. Full-ready cycle cost is also tallied.
  task automatic model(input int max_issue, input int rd_pc, input int rd_tgt, input bit rd_acc);
    int pc;
    bit inj;
    logic [15:0] w;
    exp_pc.delete();
    exp_in.delete();
    exp_halt = 1'b0;
    exp_cyc = 0;
    pc = 0;
    inj = 1'b0;
    for (int s = 0; s < 4000 && exp_pc.size() < max_issue; s++) begin
      w = ref_mem[pc];
      if (w[15:12] == 4'hF) begin
        exp_halt = 1'b1;
        exp_cyc += 1;
        break;
      end
      if (w[15:12] == 4'hE) begin
        pc = int'(w[7:0]);
        exp_cyc += 1;
        continue;
      end
      exp_cyc += 2;
      if (!inj && rd_pc == pc) begin
        inj = 1'b1;
        if (rd_acc) begin
          exp_pc.push_back(pc);
          exp_in.push_back(w);
        end
        pc = rd_tgt;
        continue;
      end
      exp_pc.push_back(pc);
      exp_in.push_back(w);
      pc = (pc + 1) % 256;
    end
  endtask

  // Start the program and drive ready/redirect/load; capture accepted words.
  task automatic run_prog(input int max_issue, input int ready_pct, input int rd_pc,
                          input int rd_tgt, input bit rd_acc, input bit poke_load);
    bit prev_valid, prev_ready, inj;
    logic [15:0] held_i;
    logic [7:0]  held_p;
    cap_pc.delete();
    cap_in.delete();
    stab_err = 0;
    halted_seen = 1'b0;
    halt_cyc = -1;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    inj = 1'b0;
    held_i = '0;
    held_p = '0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      redirect_en = 1'b0;
      load_en = 1'b0;
      if (halted) begin
        halted_seen = 1'b1;
        halt_cyc = c;
        break;
      end
      if (cap_pc.size() >= max_issue) break;
      if (prev_valid && !prev_ready && instr_valid &&
          (instr_out !== held_i || pc_out !== held_p)) stab_err++;
      instr_ready = ($urandom_range(99) < 32'(ready_pct));
      if (instr_valid && !inj && rd_pc >= 0 && int'(pc_out) == rd_pc) begin
        inj = 1'b1;
        redirect_en = 1'b1;
        redirect_pc = 8'(rd_tgt);
        instr_ready = rd_acc;
      end
      if (instr_valid && instr_ready) begin
        cap_pc.push_back(int'(pc_out));
        cap_in.push_back(instr_out);
      end
      if (poke_load && busy && c == 3) begin
        load_en = 1'b1;
        load_addr = 8'($urandom_range(40));
        load_data = 16'hF000;
      end
      held_i = instr_out;
      held_p = pc_out;
      prev_valid = instr_valid;
      prev_ready = instr_ready;
      @(negedge clk);
    end
    instr_ready = 1'b0;
    redirect_en = 1'b0;
    load_en = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (instr_out !== 16'h0000 || instr_valid !== 1'b0 || pc_out !== 8'h00 ||
        busy !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_values got instr=%h valid=%b pc=%h busy=%b halted=%b exp 0000 0 00 0 0",
               instr_out, instr_valid, pc_out, busy, halted);
    end
`ifdef FETCH_ISSUE_COUNT_EN
    checks++;
    if (issue_cnt !== 16'h0000) begin
      errors++;
      $display("FAIL reset_cnt got %h exp 0000", issue_cnt);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    load_word(0, 16'h0123);
    load_word(1, 16'h1123);
    load_word(2, 16'hF000);
    model(1000, -1, 0, 1'b0);
    run_prog(1000, 100, -1, 0, 1'b0, 1'b0);
    checks++;
    if (cap_pc.size() != exp_pc.size()) begin
      errors++;
      $display("FAIL basic_count got %0d exp %0d", cap_pc.size(), exp_pc.size());
    end
    for (int i = 0; i < cap_pc.size() && i < exp_pc.size(); i++) begin
      checks++;
      if (cap_pc[i] != exp_pc[i] || cap_in[i] !== exp_in[i]) begin
        errors++;
        $display("FAIL basic_issue[%0d] got pc=%0d instr=%h exp pc=%0d instr=%h",
                 i, cap_pc[i], cap_in[i], exp_pc[i], exp_in[i]);
      end
    end
    checks++;
    if (!halted_seen || halt_cyc != exp_cyc) begin
      errors++;
      $display("FAIL basic_halt_timing got halted=%b cyc=%0d exp halted=1 cyc=%0d",
               halted_seen, halt_cyc, exp_cyc);
    end
`ifdef FETCH_ISSUE_COUNT_EN
    checks++;
    if (issue_cnt !== 16'(exp_pc.size())) begin
      errors++;
      $display("FAIL basic_cnt got %0d exp %0d", issue_cnt, exp_pc.size());
    end
`endif
  endtask

  task automatic test_stall();
    int k;
    load_word(0, 16'h0123);
    load_word(1, 16'hF000);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    instr_ready = 1'b0;
    for (k = 0; k < 20 && !instr_valid; k++) @(negedge clk);
    for (int s = 0; s < 6; s++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr_out !== 16'h0123 || pc_out !== 8'h00) begin
        errors++;
        $display("FAIL stall_hold[%0d] got valid=%b instr=%h pc=%h exp 1 0123 00",
                 s, instr_valid, instr_out, pc_out);
      end
      if (s < 5) @(negedge clk);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_drop_valid got %b exp 0", instr_valid);
    end
    for (k = 0; k < 20 && !halted; k++) @(negedge clk);
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL stall_halt got %b exp 1", halted);
    end
`ifdef FETCH_ISSUE_COUNT_EN
    checks++;
    if (issue_cnt !== 16'd1) begin
      errors++;
      $display("FAIL stall_cnt got %0d exp 1", issue_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid_issue();
    int k;
    load_word(0, 16'h0123);
    load_word(1, 16'h1123);
    load_word(2, 16'hF000);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (k = 0; k < 40; k++) begin
      instr_ready = !(instr_valid && pc_out == 8'd1);
      if (instr_valid && pc_out == 8'd1) break;
      @(negedge clk);
    end
    checks++;
    if (instr_valid !== 1'b1 || pc_out !== 8'd1) begin
      errors++;
      $display("FAIL rstmid_reach got valid=%b pc=%h exp 1 01", instr_valid, pc_out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || busy !== 1'b0 || pc_out !== 8'h00 ||
        instr_out !== 16'h0000 || halted !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_values got valid=%b busy=%b pc=%h instr=%h halted=%b exp 0 0 00 0000 0",
               instr_valid, busy, pc_out, instr_out, halted);
    end
    instr_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_jump();
    load_word(0, 16'hE005);
    load_word(5, 16'h2456);
    load_word(6, 16'hF000);
    model(1000, -1, 0, 1'b0);
    run_prog(1000, 100, -1, 0, 1'b0, 1'b0);
    checks++;
    if (cap_pc.size() != exp_pc.size()) begin
      errors++;
      $display("FAIL jump_count got %0d exp %0d", cap_pc.size(), exp_pc.size());
    end
    for (int i = 0; i < cap_pc.size() && i < exp_pc.size(); i++) begin
      checks++;
      if (cap_pc[i] != exp_pc[i] || cap_in[i] !== exp_in[i]) begin
        errors++;
        $display("FAIL jump_issue[%0d] got pc=%0d instr=%h exp pc=%0d instr=%h",
                 i, cap_pc[i], cap_in[i], exp_pc[i], exp_in[i]);
      end
    end
    checks++;
    if (!halted_seen || halt_cyc != exp_cyc) begin
      errors++;
      $display("FAIL jump_halt_timing got halted=%b cyc=%0d exp halted=1 cyc=%0d",
               halted_seen, halt_cyc, exp_cyc);
    end
  endtask

  task automatic test_redirect(input bit acc);
    for (int i = 0; i < 10; i++) load_word(i, {4'(i % 14), 4'(i), 8'(i * 17)});
    load_word(10, 16'hF000);
    if (acc) model(1000, 2, 8, 1'b1);
    else     model(1000, 1, 8, 1'b0);
    if (acc) run_prog(1000, 100, 2, 8, 1'b1, 1'b0);
    else     run_prog(1000, 100, 1, 8, 1'b0, 1'b0);
    checks++;
    if (cap_pc.size() != exp_pc.size()) begin
      errors++;
      $display("FAIL redirect%0d_count got %0d exp %0d", acc, cap_pc.size(), exp_pc.size());
    end
    for (int i = 0; i < cap_pc.size() && i < exp_pc.size(); i++) begin
      checks++;
      if (cap_pc[i] != exp_pc[i] || cap_in[i] !== exp_in[i]) begin
        errors++;
        $display("FAIL redirect%0d_issue[%0d] got pc=%0d instr=%h exp pc=%0d instr=%h",
                 acc, i, cap_pc[i], cap_in[i], exp_pc[i], exp_in[i]);
      end
    end
    checks++;
    if (halted_seen != exp_halt) begin
      errors++;
      $display("FAIL redirect%0d_halt got %b exp %b", acc, halted_seen, exp_halt);
    end
`ifdef FETCH_ISSUE_COUNT_EN
    checks++;
    if (issue_cnt !== 16'(exp_pc.size())) begin
      errors++;
      $display("FAIL redirect%0d_cnt got %0d exp %0d", acc, issue_cnt, exp_pc.size());
    end
`endif
  endtask

  task automatic test_wrap();
    load_word(0, 16'h0333);
    load_word(1, 16'hE0FE);
    load_word(254, 16'h0AAA);
    load_word(255, 16'h0111);
    model(5, -1, 0, 1'b0);
    run_prog(5, 70, -1, 0, 1'b0, 1'b0);
    checks++;
    if (cap_pc.size() != exp_pc.size()) begin
      errors++;
      $display("FAIL wrap_count got %0d exp %0d", cap_pc.size(), exp_pc.size());
    end
    for (int i = 0; i < cap_pc.size() && i < exp_pc.size(); i++) begin
      checks++;
      if (cap_pc[i] != exp_pc[i] || cap_in[i] !== exp_in[i]) begin
        errors++;
        $display("FAIL wrap_issue[%0d] got pc=%0d instr=%h exp pc=%0d instr=%h",
                 i, cap_pc[i], cap_in[i], exp_pc[i], exp_in[i]);
      end
    end
    checks++;
    if (stab_err != 0) begin
      errors++;
      $display("FAIL wrap_stability got %0d unstable cycles exp 0", stab_err);
    end
    do_reset();
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 40; i++) begin
        if ($urandom_range(7) == 0 && i < 38)
          load_word(i, {8'hE0, 8'(i + 1 + int'($urandom_range(2)))});
        else
          load_word(i, {4'($urandom_range(13)), 12'($urandom)});
      end
      load_word(40, 16'hF000);
      model(1000, -1, 0, 1'b0);
      run_prog(1000, 50, -1, 0, 1'b0, 1'b1);
      checks++;
      if (cap_pc.size() != exp_pc.size()) begin
        errors++;
        $display("FAIL random%0d_count got %0d exp %0d", r, cap_pc.size(), exp_pc.size());
      end
      for (int i = 0; i < cap_pc.size() && i < exp_pc.size(); i++) begin
        checks++;
        if (cap_pc[i] != exp_pc[i] || cap_in[i] !== exp_in[i]) begin
          errors++;
          $display("FAIL random%0d_issue[%0d] got pc=%0d instr=%h exp pc=%0d instr=%h",
                   r, i, cap_pc[i], cap_in[i], exp_pc[i], exp_in[i]);
        end
      end
      checks++;
      if (!halted_seen || stab_err != 0) begin
        errors++;
        $display("FAIL random%0d_end got halted=%b unstable=%0d exp halted=1 unstable=0",
                 r, halted_seen, stab_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_reset_mid_issue();
    test_jump();
    test_redirect(1'b0);
    test_redirect(1'b1);
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
